// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like split-handshake bus between fetch and data ports.
// Data has fixed priority; an in-order tag FIFO routes each response back to its issuer.
module sram_bus_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic        inst_uncached,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_uncached,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_uncached,
    input  logic [31:0] bus_rdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_NONE, S_LOCK_I, S_LOCK_D} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_tag [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic w_req, w_gnt_d, w_full, w_empty, w_push, w_pop, w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    always_comb begin
        w_req        = 1'b0;
        w_gnt_d      = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_LOCK_I: begin
                w_req = 1'b1;
                if (bus_addr_ok) w_state_next = S_NONE;
            end
            S_LOCK_D: begin
                w_req   = 1'b1;
                w_gnt_d = 1'b1;
                if (bus_addr_ok) w_state_next = S_NONE;
            end
            default: begin
                // Full only gates fresh grants; a lock is never entered while full.
                if (!w_full) begin
                    if (data_req) begin
                        w_req   = 1'b1;
                        w_gnt_d = 1'b1;
                        if (!bus_addr_ok) w_state_next = S_LOCK_D;
                    end else if (inst_req) begin
                        w_req = 1'b1;
                        if (!bus_addr_ok) w_state_next = S_LOCK_I;
                    end
                end
            end
        endcase
        if (rst) begin
            w_req        = 1'b0;
            w_state_next = S_NONE;
        end
    end

    assign bus_req      = w_req;
    assign bus_wr       = w_gnt_d & data_wr;
    assign bus_size     = w_gnt_d ? data_size     : inst_size;
    assign bus_addr     = w_gnt_d ? data_addr     : inst_addr;
    assign bus_wdata    = w_gnt_d ? data_wdata    : 32'h0;
    assign bus_uncached = w_gnt_d ? data_uncached : inst_uncached;

    assign inst_addr_ok = w_req & bus_addr_ok & ~w_gnt_d;
    assign data_addr_ok = w_req & bus_addr_ok &  w_gnt_d;

    assign w_push = w_req & bus_addr_ok;
    // Responses arriving with nothing outstanding (stale after reset) are dropped.
    assign w_pop  = bus_data_ok & ~w_empty & ~rst;
    assign w_head = r_tag[r_rptr];

    assign inst_data_ok = w_pop & ~w_head;
    assign data_data_ok = w_pop &  w_head;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_NONE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_tag[r_wptr] <= w_gnt_d;
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: expected response owners are queued at
// acceptance and compared when the bench returns bus_data_ok.
module tb_sram_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_uncached;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr, data_uncached;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr, bus_uncached;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_addr_ok, bus_data_ok;

    int checks = 0;
    int failures = 0;
    bit exp_q [$];

    sram_bus_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_uncached(inst_uncached), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_uncached(data_uncached),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_uncached(bus_uncached), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    endtask

    // One response cycle: the queue decides which port must see data_ok.
    task automatic respond(input logic [31:0] rd, input string tag);
        bit has = 0;
        bit own = 0;
        inst_req = 0; data_req = 0; bus_addr_ok = 0;
        bus_data_ok = 1; bus_rdata = rd;
        #1;
        if (exp_q.size() > 0) begin
            has = 1;
            own = exp_q.pop_front();
        end
        chk({tag, "_inst_data_ok"}, {31'b0, inst_data_ok}, {31'b0, has & ~own});
        chk({tag, "_data_data_ok"}, {31'b0, data_data_ok}, {31'b0, has & own});
        if (has) chk({tag, "_rdata"}, own ? data_rdata : inst_rdata, rd);
        $display("resp %s has=%0d owner=%0d rdata=%08h", tag, has, own, rd);
        cyc();
        bus_data_ok = 0;
    endtask

    task automatic accept_inst(input logic [31:0] a, input string tag);
        inst_req = 1; inst_addr = a; bus_addr_ok = 1; bus_data_ok = 0;
        #1;
        chk({tag, "_bus_req"}, {31'b0, bus_req}, 32'd1);
        chk({tag, "_bus_addr"}, bus_addr, a);
        chk({tag, "_inst_addr_ok"}, {31'b0, inst_addr_ok}, 32'd1);
        exp_q.push_back(1'b0);
        $display("req inst addr=%08h", a);
        cyc();
    endtask

    initial begin
        rst = 1; idle();
        inst_size = 2; inst_addr = 32'hBFC00000; inst_uncached = 1;
        data_wr = 0; data_size = 2; data_addr = 32'h80001000; data_wdata = 32'h0; data_uncached = 0;
        bus_rdata = 0;
        cyc();
        // Reset: outputs held low even with both requests and a response present.
        inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
        #1;
        chk("rst_bus_req", {31'b0, bus_req}, 0);
        chk("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 0);
        cyc();
        rst = 0; idle(); cyc();

        // Single fetch, response two cycles later.
        accept_inst(32'hBFC00000, "t1");
        idle(); cyc();
        respond(32'h3C080001, "t1");

        // Simultaneous requests: data first, then inst.
        inst_req = 1; data_req = 1; data_wr = 0; bus_addr_ok = 1;
        #1;
        chk("t2_data_addr_ok", {31'b0, data_addr_ok}, 1);
        chk("t2_inst_addr_ok0", {31'b0, inst_addr_ok}, 0);
        chk("t2_bus_addr", bus_addr, 32'h80001000);
        exp_q.push_back(1'b1);
        cyc();
        data_req = 0;
        #1;
        chk("t2_inst_addr_ok1", {31'b0, inst_addr_ok}, 1);
        chk("t2_inst_wdata", bus_wdata, 0);
        exp_q.push_back(1'b0);
        cyc();
        respond(32'h11111111, "t2a");
        respond(32'h22222222, "t2b");
        respond(32'h33333333, "t2_empty");

        // Data lock with inst toggling, bus stalls three cycles.
        data_req = 1; data_wr = 1; data_wdata = 32'hDEADBEEF; data_addr = 32'h80001000;
        bus_addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            inst_req = i[0]; inst_addr = 32'hBFC00040;
            #1;
            chk("t3_bus_addr", bus_addr, 32'h80001000);
            chk("t3_bus_wr", {31'b0, bus_wr}, 1);
            chk("t3_inst_addr_ok", {31'b0, inst_addr_ok}, 0);
            $display("lockd cycle %0d bus_addr=%08h", i, bus_addr);
            cyc();
        end
        bus_addr_ok = 1; inst_req = 1;
        #1;
        chk("t3_data_addr_ok", {31'b0, data_addr_ok}, 1);
        chk("t3_wdata", bus_wdata, 32'hDEADBEEF);
        exp_q.push_back(1'b1);
        cyc();
        data_req = 0; data_wr = 0;
        respond(32'h44444444, "t3");

        // Inst lock: data arriving later must not steal the bus.
        inst_req = 1; inst_addr = 32'hBFC00080; bus_addr_ok = 0;
        cyc();
        data_req = 1;
        #1;
        chk("t4_locki_addr", bus_addr, 32'hBFC00080);
        cyc();
        bus_addr_ok = 1;
        #1;
        chk("t4_inst_addr_ok", {31'b0, inst_addr_ok}, 1);
        chk("t4_data_addr_ok", {31'b0, data_addr_ok}, 0);
        exp_q.push_back(1'b0);
        cyc();
        inst_req = 0;
        #1;
        chk("t4_data_after", {31'b0, data_addr_ok}, 1);
        exp_q.push_back(1'b1);
        cyc();
        respond(32'h55555555, "t4a");
        respond(32'h66666666, "t4b");

        // Full: four outstanding fetches block the fifth.
        for (int i = 0; i < 4; i++) accept_inst(32'hBFC00100 + 32'(i * 4), "t5");
        inst_req = 1; bus_addr_ok = 1;
        #1;
        chk("t5_full_bus_req", {31'b0, bus_req}, 0);
        chk("t5_full_addr_ok", {31'b0, inst_addr_ok}, 0);
        cyc();
        bus_data_ok = 1; bus_rdata = 32'h77777777;
        #1;
        chk("t5_pop_inst_data_ok", {31'b0, inst_data_ok}, 1);
        chk("t5_pop_same_bus_req", {31'b0, bus_req}, 0);
        void'(exp_q.pop_front());
        cyc();
        bus_data_ok = 0;
        #1;
        chk("t5_next_bus_req", {31'b0, bus_req}, 1);
        chk("t5_next_addr_ok", {31'b0, inst_addr_ok}, 1);
        exp_q.push_back(1'b0);
        cyc();
        for (int i = 0; i < 4; i++) respond(32'h80000000 + 32'(i), "t5_drain");

        // Stray response with empty FIFO.
        respond(32'h99999999, "t6_stray");

        // Reset with two outstanding discards them.
        accept_inst(32'hBFC00200, "t7");
        accept_inst(32'hBFC00204, "t7");
        idle(); rst = 1; cyc();
        rst = 0; exp_q.delete(); cyc();
        respond(32'hAAAAAAAA, "t7_stale0");
        respond(32'hBBBBBBBB, "t7_stale1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
